// File: rtl/ysyx_23060025_rxbar_if.sv
// AXI-lite-style read channel (AR + R) shared by the LSU port and both slave ports of the read crossbar.
interface ysyx_23060025_rxbar_if #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
);
    logic [ADDR_LEN-1:0] ar_addr;
    logic                ar_valid;
    logic                ar_ready;
    logic [DATA_LEN-1:0] r_data;
    logic [1:0]          r_resp;
    logic                r_valid;
    logic                r_last;
    logic                r_ready;

    modport master (
        output ar_addr, ar_valid, r_ready,
        input  ar_ready, r_data, r_resp, r_valid, r_last
    );

    modport slave (
        input  ar_addr, ar_valid, r_ready,
        output ar_ready, r_data, r_resp, r_valid, r_last
    );
endinterface

// File: rtl/ysyx_23060025_rxbar.sv
// Single-master, two-slave read crossbar (LSU -> CLINT / memory), one transaction in flight.
// Define RXBAR_DECERR_EN to answer unmapped addresses with a decode error instead of routing them to memory.
//
// state | meaning
// IDLE  | accepting a new read address from the master
// ADDR  | presenting addr_q to the selected slave
// DATA  | passing the selected slave's read beats through to the master
// ERR   | returning a single decode-error beat
module ysyx_23060025_rxbar #(
    parameter int                  ADDR_LEN   = 32,
    parameter int                  DATA_LEN   = 32,
    parameter logic [ADDR_LEN-1:0] CLINT_BASE = 32'h0200_0000,
    parameter logic [ADDR_LEN-1:0] CLINT_SIZE = 32'h0001_0000,
    parameter logic [ADDR_LEN-1:0] MEM_BASE   = 32'h8000_0000,
    parameter logic [ADDR_LEN-1:0] MEM_SIZE   = 32'h0800_0000
) (
    input  logic                  clock,
    input  logic                  rstn,
    ysyx_23060025_rxbar_if.slave  m,
    ysyx_23060025_rxbar_if.master c,
    ysyx_23060025_rxbar_if.master s
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;

    state_t              state;
    state_t              state_nx;
    logic [ADDR_LEN-1:0] addr_q;
    logic [1:0]          sel_q;
    logic [1:0]          sel_dec;
    logic [ADDR_LEN-1:0] off_c;
    logic                hit_c;

    // Offset compare wraps at ADDR_LEN bits, so a window may sit anywhere in the map.
    assign off_c = m.ar_addr - CLINT_BASE;
    assign hit_c = off_c < CLINT_SIZE;

`ifdef RXBAR_DECERR_EN
    logic [ADDR_LEN-1:0] off_s;
    logic                hit_s;
    assign off_s   = m.ar_addr - MEM_BASE;
    assign hit_s   = off_s < MEM_SIZE;
    assign sel_dec = hit_c ? 2'b01 : (hit_s ? 2'b10 : 2'b00);
`else
    logic unused_mem_window;
    assign unused_mem_window = ^{MEM_BASE, MEM_SIZE};
    assign sel_dec = hit_c ? 2'b01 : 2'b10;
`endif

    always_ff @(posedge clock) begin
        if (!rstn) begin
            state  <= IDLE;
            addr_q <= '0;
            sel_q  <= 2'b00;
        end else begin
            state <= state_nx;
            if (state == IDLE && m.ar_valid) begin
                addr_q <= m.ar_addr;
                sel_q  <= sel_dec;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        m.ar_ready = 1'b0;
        m.r_data   = '0;
        m.r_resp   = 2'b00;
        m.r_valid  = 1'b0;
        m.r_last   = 1'b0;
        c.ar_addr  = '0;
        c.ar_valid = 1'b0;
        c.r_ready  = 1'b0;
        s.ar_addr  = '0;
        s.ar_valid = 1'b0;
        s.r_ready  = 1'b0;
        case (state)
            IDLE: begin
                m.ar_ready = rstn;
                if (m.ar_valid) state_nx = (sel_dec == 2'b00) ? ERR : ADDR;
            end
            ADDR: begin
                if (sel_q == 2'b01) begin
                    c.ar_valid = 1'b1;
                    c.ar_addr  = addr_q;
                    if (c.ar_ready) state_nx = DATA;
                end else if (sel_q == 2'b10) begin
                    s.ar_valid = 1'b1;
                    s.ar_addr  = addr_q;
                    if (s.ar_ready) state_nx = DATA;
                end
            end
            DATA: begin
                if (sel_q == 2'b01) begin
                    m.r_data  = c.r_data;
                    m.r_resp  = c.r_resp;
                    m.r_valid = c.r_valid;
                    m.r_last  = c.r_last;
                    c.r_ready = m.r_ready;
                    if (c.r_valid && m.r_ready && c.r_last) state_nx = IDLE;
                end else if (sel_q == 2'b10) begin
                    m.r_data  = s.r_data;
                    m.r_resp  = s.r_resp;
                    m.r_valid = s.r_valid;
                    m.r_last  = s.r_last;
                    s.r_ready = m.r_ready;
                    if (s.r_valid && m.r_ready && s.r_last) state_nx = IDLE;
                end
            end
            ERR: begin
                m.r_valid = 1'b1;
                m.r_last  = 1'b1;
                m.r_resp  = 2'b11;
                if (m.r_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: doc/ysyx_23060025_rxbar.md
# ysyx_23060025_rxbar
Single-master, two-slave AXI-lite-style read crossbar between the LSU read port and the CLINT/memory slaves. Decodes each read address, forwards it to exactly one slave, and returns that slave's read-data beat to the master. It is the stage directly upstream of the CLINT. One transaction is outstanding at a time; the target is registered for the whole transaction.
## Interface
- ADDR_LEN, 32, address width
- DATA_LEN, 32, data width
- CLINT_BASE, 32'h0200_0000, CLINT window base (inclusive)
- CLINT_SIZE, 32'h0001_0000, CLINT window size in bytes
- MEM_BASE, 32'h8000_0000, memory window base; MEM_SIZE, 32'h0800_0000, memory window size
- clock  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- m_ar_addr_i / m_ar_valid_i / m_ar_ready_o  in/in/out  ADDR_LEN/1/1  master read address
- m_r_data_o / m_r_resp_o  out  DATA_LEN/2  master read data and response
- m_r_valid_o / m_r_last_o / m_r_ready_i  out/out/in  1/1/1  master read handshake
- c_ar_addr_o / c_ar_valid_o / c_ar_ready_i  out/out/in  ADDR_LEN/1/1  CLINT read address
- c_r_data_i / c_r_resp_i / c_r_valid_i / c_r_last_i / c_r_ready_o  in/in/in/in/out  DATA_LEN/2/1/1/1  CLINT read data
- s_ar_addr_o / s_ar_valid_o / s_ar_ready_i  out/out/in  ADDR_LEN/1/1  memory read address
- s_r_data_i / s_r_resp_i / s_r_valid_i / s_r_last_i / s_r_ready_o  in/in/in/in/out  DATA_LEN/2/1/1/1  memory read data
## Operation
- States: IDLE, ADDR, DATA, ERR. Registers: state, addr_q (ADDR_LEN), sel_q (2'b01 CLINT, 2'b10 MEM, 2'b00 none).
- Decode: hit_c = (addr - CLINT_BASE) < CLINT_SIZE, unsigned, ADDR_LEN-bit wrap; hit_s likewise; CLINT has priority on overlap.
- IDLE: m_ar_ready_o = 1. On m_ar_valid_i: latch addr_q, sel_q; -> ADDR if hit, else per Configuration.
- ADDR: selected slave's ar_valid_o = 1, ar_addr_o = addr_q; other slave's ar_valid_o = 0. On selected ar_ready_i -> DATA.
- DATA: master r channel muxed combinationally from selected slave (data, resp, valid, last); selected slave r_ready_o = m_r_ready_i, other = 0. On valid & ready & last -> IDLE; valid & ready & !last stays DATA (bursts passed through).
- ERR: m_r_valid_o = 1, m_r_last_o = 1, m_r_resp_o = 2'b11, m_r_data_o = 0; on m_r_ready_i -> IDLE.
- Outside IDLE m_ar_ready_o = 0; unselected slave outputs all 0; master r outputs 0 when not in DATA/ERR.
- Reset: state IDLE, addr_q 0, sel_q 0; all valid outputs 0; m_ar_ready_o 0 while rstn = 0. Reset mid-transaction abandons it; slaves reset by the same rstn.
## Timing
- Accept at edge T0; slave ar_valid_o high from T0+1; with combinational slave ar_ready (CLINT), address handshake at T0+1.
- CLINT with no delay: c_r_valid_i at T0+2 -> m_r_valid_o at T0+2 (zero-cycle pass-through); next accept earliest T0+3.
- ERR response valid at T0+1.
- Slave r_valid_i asserted during ADDR is ignored (not forwarded).
- Back-to-back: ready returns in the cycle after final beat handshake; no bypass of IDLE.
## Configuration
- RXBAR_DECERR_EN defined: address missing both windows -> ERR, no slave sees the request.
- Undefined: any non-CLINT address routes to memory (sel_q = 2'b10); ERR state and 2'b11 response never produced.
## Test plan
- Read 32'h0200_BFF8 with CLINT ready/valid immediate -> c_ar_valid_o at T0+1, m_r_valid_o at T0+2 with CLINT data, resp 0, last 1; s_ar_valid_o never high.
- Read 32'h8000_0010, memory ar_ready after 3 cycles, r_valid after 4 more, m_r_ready low 2 cycles -> data held stable until handshake; return to IDLE next cycle.
- Read 32'h1000_0000 with RXBAR_DECERR_EN -> m_r_valid at T0+1, resp 2'b11, data 0; without macro -> forwarded to memory.
- 4-beat memory burst, last on beat 4 -> four master beats, IDLE only after beat 4.
- rstn low during DATA -> next cycle state IDLE, all valids 0, m_ar_ready_o 1 after rstn high.
- Two back-to-back reads CLINT then memory, m_ar_valid_i held high -> second accepted the cycle after first completes, routed to memory.
